core_seq: RTL
=============

# core_seq

Multi-cycle sequencer for the RV32 core datapath (PC register, instruction decoder, ALU, register file). It fetches each instruction over a request/valid memory handshake and holds it stable for the decoder. It steps the datapath through DECODE, EXEC and WB, gates the register-file write enable and advances the PC. It stops on `ebreak` (halt), on an illegal instruction, or on a fetch timeout (trap), and counts retired instructions.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC value after reset; bits [1:0] must be 00.
- FETCH_TIMEOUT, 255, maximum cycles spent in FETCH without `imem_rvalid` before trapping; range 1..255.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- run  in  1  permission to start the next instruction.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; always equals `pc`.
- imem_rvalid  in  1  fetch data valid.
- imem_rdata  in  32  fetched instruction word.
- inst  out  32  latched instruction, fed to the decoder.
- pc  out  32  current PC.
- dec_legal  in  1  decoder reports that `inst` is supported.
- dec_ebreak  in  1  decoder reports that `inst` is `ebreak`.
- rf_wen  out  1  register-file write enable.
- halted  out  1  sticky; `ebreak` reached.
- trap  out  1  sticky; illegal instruction or fetch timeout.
- trap_cause  out  2  00 none, 01 illegal, 10 fetch timeout.
- instret  out  32  retired-instruction count; wraps to 0.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT, TRAP.
- IDLE: when `run`=1, go to FETCH. Otherwise stay.
- FETCH: `imem_req`=1 and `imem_addr`=`pc`, both held stable until `imem_rvalid`=1 is sampled.
  - On `imem_rvalid`: `inst` <= `imem_rdata`, go to DECODE, clear the timeout counter.
  - The timeout counter increments on each FETCH cycle without `imem_rvalid`. When it reaches FETCH_TIMEOUT: go to TRAP with `trap_cause`=10.
  - `imem_rvalid` while not in FETCH is ignored.
- DECODE: priority `dec_ebreak` > `!dec_legal` > normal.
  - `dec_ebreak`: go to HALT.
  - `!dec_legal`: go to TRAP with `trap_cause`=01.
  - Otherwise go to EXEC.
- EXEC: one cycle for the ALU result to settle. Go to WB.
- WB:
  - `rf_wen`=1 for this cycle only.
  - On the closing edge: `pc` <= `pc`+4 (mod 2^32; 0xFFFF_FFFC wraps to 0) and `instret` <= `instret`+1 (wraps).
  - Next state is FETCH if `run`=1, else IDLE.
- HALT: `halted`=1. TRAP: `trap`=1. Both are terminal: `pc`, `inst` and `instret` are frozen, and only `rst` exits.
- `ebreak` and trapping instructions do not retire: no `rf_wen`, no PC advance, no `instret` increment.
- Deasserting `run` never aborts an instruction in flight. It is sampled only in IDLE and WB.

## Timing
- Reset (asynchronous, immediate, including mid-fetch or mid-WB):
  - state=IDLE, `pc`=RESET_PC, `inst`=32'h0000_0013, `rf_wen`=0, `imem_req`=0.
  - `halted`=0, `trap`=0, `trap_cause`=00, `instret`=0, timeout counter=0.
  - A fetch interrupted by reset is abandoned. A late `imem_rvalid` is ignored because the block is not in FETCH.
- Zero-wait fetch (`imem_rvalid` high in the first FETCH cycle) gives 4 cycles per instruction: FETCH, DECODE, EXEC, WB. Each wait cycle adds one.
- `imem_addr` is a direct copy of the `pc` register and carries no combinational path from inputs.
- `inst` is stable from the DECODE cycle through WB. `dec_*` inputs are sampled only in DECODE.
- In WB, `pc` still shows the old value. The register file writes on the same edge that advances `pc`.
- `halted`/`trap` rise on the edge that leaves DECODE (or FETCH, for timeout).

## Test plan
- Reset then `run`=1, zero-wait memory returning 0x0010_0093 (addi x1,x0,1) legal:
  - `imem_addr`=0x8000_0000 in cycle 1.
  - `rf_wen` high exactly in cycle 4.
  - `pc`=0x8000_0004 and `instret`=1 in cycle 5, with the next FETCH active.
- 3 wait cycles on fetch:
  - `imem_req` high for 4 cycles with `imem_addr` constant.
  - `rf_wen` in cycle 7.
  - A late `imem_rvalid` pulse during EXEC has no effect.
- DECODE with `dec_ebreak`=1 (0x0010_0073): `halted`=1, no `rf_wen`, `pc` and `instret` unchanged, `imem_req` stays 0 for 20 cycles.
- `dec_legal`=0: `trap`=1, `trap_cause`=01. With no `imem_rvalid` for 255 FETCH cycles: `trap`=1, `trap_cause`=10 on the 255th-cycle edge.
- `pc` preloaded via RESET_PC=0xFFFF_FFFC, one legal instruction: `pc`=0x0000_0000 after WB.
- `run` dropped during EXEC: WB completes, then IDLE with `imem_req`=0. `rst` asserted mid-WB: all outputs at reset values immediately, no `instret` increment.

Source files
------------

// File: rtl/core_seq.sv
// Multi-cycle sequencer for the RV32 datapath: fetch handshake, DECODE/EXEC/WB stepping,
// register-file write gating, PC advance, halt/trap detection and retired-instruction count.
module core_seq #(
    parameter logic [31:0] RESET_PC      = 32'h8000_0000,
    parameter int          FETCH_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic        dec_legal,
    input  logic        dec_ebreak,
    output logic        rf_wen,
    output logic        halted,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT, S_TRAP
    } state_t;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    // Value of the wait counter during the last FETCH cycle allowed before trapping.
    localparam logic [7:0]  TO_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] tcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (run) state_nxt = S_FETCH;
            S_FETCH: begin
                if (imem_rvalid)          state_nxt = S_DECODE;
                else if (tcnt == TO_LAST) state_nxt = S_TRAP;
            end
            S_DECODE: begin
                if (dec_ebreak)      state_nxt = S_HALT;
                else if (!dec_legal) state_nxt = S_TRAP;
                else                 state_nxt = S_EXEC;
            end
            S_EXEC:   state_nxt = S_WB;
            S_WB:     state_nxt = run ? S_FETCH : S_IDLE;
            S_HALT:   state_nxt = S_HALT;
            S_TRAP:   state_nxt = S_TRAP;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            inst       <= NOP;
            instret    <= '0;
            trap_cause <= 2'b00;
            tcnt       <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_rvalid) begin
                        inst <= imem_rdata;
                        tcnt <= '0;
                    end else if (tcnt == TO_LAST) begin
                        trap_cause <= 2'b10;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                S_DECODE: if (!dec_ebreak && !dec_legal) trap_cause <= 2'b01;
                // Retire: the register file writes on this same edge.
                S_WB: begin
                    pc      <= pc + 32'd4;
                    instret <= instret + 32'd1;
                end
                default: ;
            endcase
        end
    end

    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc;
    assign rf_wen    = (state == S_WB);
    assign halted    = (state == S_HALT);
    assign trap      = (state == S_TRAP);

endmodule
